// File: rtl/vram_seq_pkg.sv
// Shared types and helpers for the VRAM slot sequencer: window kinds,
// default layer count and a constant-friendly ceil(log2) helper.
package vram_seq_pkg;

    localparam int DEF_NUM_LAYERS = 3;
    // The CPU owns the slot just past the last layer slot.
    localparam int CPU_SLOT = DEF_NUM_LAYERS;

    typedef enum logic [1:0] {
        WIN_IDLE,
        WIN_LAYER,
        WIN_CPU_RD,
        WIN_CPU_WR
    } win_kind_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/vram_slot_timer.sv
// Free-running phase/slot counters for the VRAM slot schedule. win_start and
// win_last look one edge ahead so the top level can register its outputs.
module vram_slot_timer
    import vram_seq_pkg::*;
#(
    parameter int NUM_LAYERS = CPU_SLOT,
    parameter int SLOT_LEN   = 2,
    localparam int SW        = clog2(NUM_LAYERS + 1),
    localparam int PW        = clog2(SLOT_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          win_start,
    output logic          win_last,
    output logic [SW-1:0] slot,
    output logic [SW-1:0] slot_nxt
);

    localparam logic [PW-1:0] PH_LAST   = PW'(SLOT_LEN - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_LAYERS);

    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;
    logic [SW-1:0] slot_q;
    logic [SW-1:0] slot_d;

    // win_start: the coming edge opens a window; win_last: the cycle after
    // the coming edge is the final cycle of its window.
    always_comb begin
        win_start = (ph_q == PH_LAST);
        ph_d      = win_start ? '0 : ph_q + 1'b1;
        slot_d    = slot_q;
        if (win_start) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
        win_last  = (ph_d == PH_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= '0;
            slot_q <= '0;
        end else begin
            ph_q   <= ph_d;
            slot_q <= slot_d;
        end
    end

    assign slot     = slot_q;
    assign slot_nxt = slot_d;

endmodule

// File: rtl/vram_slot_sequencer.sv
// Round-robin VRAM bus sequencer: layer fetch windows plus one CPU window,
// with registered address, chip-select/enable strobes and data-valid pulses.
module vram_slot_sequencer
    import vram_seq_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int SLOT_LEN   = 2,
    localparam int SW        = clog2(NUM_LAYERS + 1)
) (
    input  logic                         M24,
    input  logic                         RESn,
    input  logic [NUM_LAYERS*ADDR_W-1:0] LAYER_ADDR,
    input  logic [ADDR_W-1:0]            CPU_ADDR,
    input  logic                         CPU_REQ,
    input  logic                         CPU_WE,
    input  logic                         DISPLAY_EN,
    output logic [ADDR_W-1:0]            RA,
    output logic                         VRAM_CSn,
    output logic                         VRAM_OEn,
    output logic                         VRAM_WEn,
    output logic [NUM_LAYERS-1:0]        LAYER_STROBE,
    output logic                         CPU_ACK,
    output logic [SW-1:0]                SLOT,
    output win_kind_t                    dbg_win_kind
);

    localparam logic [SW-1:0] CPU_SLOT_IDX = SW'(NUM_LAYERS);

    logic          win_start;
    logic          win_last;
    logic [SW-1:0] slot;
    logic [SW-1:0] slot_nxt;

    vram_slot_timer #(
        .NUM_LAYERS (NUM_LAYERS),
        .SLOT_LEN   (SLOT_LEN)
    ) u_timer (
        .clk       (M24),
        .rst_n     (RESn),
        .win_start (win_start),
        .win_last  (win_last),
        .slot      (slot),
        .slot_nxt  (slot_nxt)
    );

    win_kind_t             kind_q;
    win_kind_t             kind_d;
    logic [ADDR_W-1:0]     ra_q;
    logic [ADDR_W-1:0]     ra_d;
    logic                  csn_q;
    logic                  csn_d;
    logic                  oen_q;
    logic                  oen_d;
    logic                  wen_q;
    logic                  wen_d;
    logic [NUM_LAYERS-1:0] strobe_q;
    logic [NUM_LAYERS-1:0] strobe_d;
    logic                  ack_q;
    logic                  ack_d;

    // CPU handshake: CPU_REQ/CPU_WE/CPU_ADDR are sampled only at a window
    // start; a granted access always runs its full window and ends with a
    // one-cycle CPU_ACK on the last cycle. The requester drops CPU_REQ the
    // cycle after ACK, otherwise the next CPU window is a fresh access.
    always_comb begin
        kind_d = kind_q;
        ra_d   = ra_q;
        if (win_start) begin
            if (DISPLAY_EN && (slot_nxt != CPU_SLOT_IDX)) begin
                kind_d = WIN_LAYER;
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    if (slot_nxt == SW'(k)) begin
                        ra_d = LAYER_ADDR[k*ADDR_W +: ADDR_W];
                    end
                end
            end else if (CPU_REQ) begin
                kind_d = CPU_WE ? WIN_CPU_WR : WIN_CPU_RD;
                ra_d   = CPU_ADDR;
            end else begin
                kind_d = WIN_IDLE;
            end
        end

        csn_d = (kind_d == WIN_IDLE);
        oen_d = !((kind_d == WIN_LAYER) || (kind_d == WIN_CPU_RD));
        // Write enable waits one cycle so the address settles under CSn first.
        wen_d = !((kind_d == WIN_CPU_WR) && !win_start);

        strobe_d = '0;
        ack_d    = 1'b0;
        if (win_last) begin
            if (kind_d == WIN_LAYER) begin
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    strobe_d[k] = (slot_nxt == SW'(k));
                end
            end
            ack_d = (kind_d == WIN_CPU_RD) || (kind_d == WIN_CPU_WR);
        end
    end

    always_ff @(posedge M24 or negedge RESn) begin
        if (!RESn) begin
            kind_q   <= WIN_IDLE;
            ra_q     <= '0;
            csn_q    <= 1'b1;
            oen_q    <= 1'b1;
            wen_q    <= 1'b1;
            strobe_q <= '0;
            ack_q    <= 1'b0;
        end else begin
            kind_q   <= kind_d;
            ra_q     <= ra_d;
            csn_q    <= csn_d;
            oen_q    <= oen_d;
            wen_q    <= wen_d;
            strobe_q <= strobe_d;
            ack_q    <= ack_d;
        end
    end

    assign RA           = ra_q;
    assign VRAM_CSn     = csn_q;
    assign VRAM_OEn     = oen_q;
    assign VRAM_WEn     = wen_q;
    assign LAYER_STROBE = strobe_q;
    assign CPU_ACK      = ack_q;
    assign SLOT         = slot;
    assign dbg_win_kind = kind_q;

endmodule

// File: tb/tb_vram_slot_sequencer.sv
// Bench for vram_slot_sequencer: three configurations (3x2, 3x4, 5x2) driven
// together and compared every cycle against a cycle-count reference model.
module tb_vram_slot_sequencer;

    localparam int AW = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] cpu_addr;
    logic          cpu_req;
    logic          cpu_we;
    logic          disp_en;
    logic [AW-1:0] lay [0:2][0:4];
    logic [3*AW-1:0] la0;
    logic [3*AW-1:0] la1;
    logic [5*AW-1:0] la2;

    logic [AW-1:0] ra_o  [0:2];
    logic          csn_o [0:2];
    logic          oen_o [0:2];
    logic          wen_o [0:2];
    logic          ack_o [0:2];
    logic [2:0]    st0;
    logic [2:0]    st1;
    logic [4:0]    st2;
    logic [1:0]    s0;
    logic [1:0]    s1;
    logic [2:0]    s2;
    logic [1:0]    k0;
    logic [1:0]    k1;
    logic [1:0]    k2;

    int total = 0;
    int bad = 0;

    int            n_m    [0:2];
    int            kind_m [0:2];
    logic [AW-1:0] ra_m   [0:2];

    always_comb begin
        la0 = '0;
        la1 = '0;
        la2 = '0;
        for (int k = 0; k < 3; k++) begin
            la0[k*AW +: AW] = lay[0][k];
            la1[k*AW +: AW] = lay[1][k];
        end
        for (int k = 0; k < 5; k++) begin
            la2[k*AW +: AW] = lay[2][k];
        end
    end

    vram_slot_sequencer #(.ADDR_W(AW), .NUM_LAYERS(3), .SLOT_LEN(2)) dut0 (
        .M24(clk), .RESn(rst_n), .LAYER_ADDR(la0), .CPU_ADDR(cpu_addr),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .DISPLAY_EN(disp_en),
        .RA(ra_o[0]), .VRAM_CSn(csn_o[0]), .VRAM_OEn(oen_o[0]), .VRAM_WEn(wen_o[0]),
        .LAYER_STROBE(st0), .CPU_ACK(ack_o[0]), .SLOT(s0), .dbg_win_kind(k0));

    vram_slot_sequencer #(.ADDR_W(AW), .NUM_LAYERS(3), .SLOT_LEN(4)) dut1 (
        .M24(clk), .RESn(rst_n), .LAYER_ADDR(la1), .CPU_ADDR(cpu_addr),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .DISPLAY_EN(disp_en),
        .RA(ra_o[1]), .VRAM_CSn(csn_o[1]), .VRAM_OEn(oen_o[1]), .VRAM_WEn(wen_o[1]),
        .LAYER_STROBE(st1), .CPU_ACK(ack_o[1]), .SLOT(s1), .dbg_win_kind(k1));

    vram_slot_sequencer #(.ADDR_W(AW), .NUM_LAYERS(5), .SLOT_LEN(2)) dut2 (
        .M24(clk), .RESn(rst_n), .LAYER_ADDR(la2), .CPU_ADDR(cpu_addr),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .DISPLAY_EN(disp_en),
        .RA(ra_o[2]), .VRAM_CSn(csn_o[2]), .VRAM_OEn(oen_o[2]), .VRAM_WEn(wen_o[2]),
        .LAYER_STROBE(st2), .CPU_ACK(ack_o[2]), .SLOT(s2), .dbg_win_kind(k2));

    function automatic int nl_of(input int d);
        return (d == 2) ? 5 : 3;
    endfunction

    function automatic int len_of(input int d);
        return (d == 1) ? 4 : 2;
    endfunction

    function automatic logic [31:0] st_of(input int d);
        case (d)
            0:       return 32'(st0);
            1:       return 32'(st1);
            default: return 32'(st2);
        endcase
    endfunction

    function automatic logic [31:0] slot_of(input int d);
        case (d)
            0:       return 32'(s0);
            1:       return 32'(s1);
            default: return 32'(s2);
        endcase
    endfunction

    function automatic logic [31:0] kind_of(input int d);
        case (d)
            0:       return 32'(k0);
            1:       return 32'(k1);
            default: return 32'(k2);
        endcase
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            n_m[d]    = 0;
            kind_m[d] = 0;
            ra_m[d]   = '0;
        end
    endtask

    // Window w starts after edge w*L (w >= 1); kind 0 idle, 1 layer, 2 read, 3 write.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 3; d++) begin
                int l;
                int nl;
                int s;
                l  = len_of(d);
                nl = nl_of(d);
                n_m[d]++;
                if (n_m[d] % l == 0) begin
                    s = (n_m[d] / l) % (nl + 1);
                    if (disp_en && s < nl) begin
                        kind_m[d] = 1;
                        ra_m[d]   = lay[d][s];
                    end else if (cpu_req) begin
                        kind_m[d] = cpu_we ? 3 : 2;
                        ra_m[d]   = cpu_addr;
                    end else begin
                        kind_m[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            int l;
            int nl;
            int ph;
            int s;
            int k;
            l  = len_of(d);
            nl = nl_of(d);
            ph = n_m[d] % l;
            s  = (n_m[d] / l) % (nl + 1);
            k  = kind_m[d];
            chk("ra", d, 32'(ra_o[d]), 32'(ra_m[d]));
            chk("csn", d, 32'(csn_o[d]), 32'(k == 0));
            chk("oen", d, 32'(oen_o[d]), 32'(!(k == 1 || k == 2)));
            chk("wen", d, 32'(wen_o[d]), 32'(!(k == 3 && ph != 0)));
            chk("strobe", d, st_of(d), (k == 1 && ph == l - 1) ? (1 << s) : 0);
            chk("ack", d, 32'(ack_o[d]), 32'(k >= 2 && ph == l - 1));
            chk("slot", d, slot_of(d), 32'(s));
            chk("kind", d, kind_of(d), 32'(k));
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        check_all();
    endtask

    initial begin
        int found;
        int cnt_cs;
        int cnt_we;
        int acks;
        int strobes;
        int prev;
        int max_slot;
        logic [31:0] st;

        cpu_addr = '0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        disp_en  = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 5; k++) begin
                lay[d][k] = AW'((k + 1) * 'h400);
            end
        end
        model_reset();

        // Reset values while RESn is held low.
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ra", d, 32'(ra_o[d]), 0);
            chk("rst_csn", d, 32'(csn_o[d]), 1);
            chk("rst_oen", d, 32'(oen_o[d]), 1);
            chk("rst_wen", d, 32'(wen_o[d]), 1);
            chk("rst_strobe", d, st_of(d), 0);
            chk("rst_ack", d, 32'(ack_o[d]), 0);
            chk("rst_slot", d, slot_of(d), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Display-only schedule, no CPU traffic.
        repeat (24) step();

        // CPU read raised during slot 1 of the 3x2 configuration.
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            step();
            if (s0 == 2'd1) found = 1;
        end
        chk("wait_slot1", 0, 32'(found), 1);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h1ABC;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            step();
            if (ack_o[0]) begin
                found = 1;
                chk("rd_ra", 0, 32'(ra_o[0]), 32'h1ABC);
                chk("rd_oen", 0, 32'(oen_o[0]), 0);
                chk("rd_slot", 0, slot_of(0), 3);
            end
        end
        chk("rd_ack_seen", 0, 32'(found), 1);
        cpu_req = 1'b0;

        // CPU write on the 4-cycle-slot configuration, address toggled mid-window.
        repeat (3) step();
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 13'h0555;
        cnt_cs = 0;
        cnt_we = 0;
        found  = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (!csn_o[1] && oen_o[1]) begin
                cnt_cs++;
                if (!wen_o[1]) cnt_we++;
                if (ack_o[1]) begin
                    found = 1;
                    chk("wr_ra", 1, 32'(ra_o[1]), 32'h0555);
                end else begin
                    cpu_addr = AW'($urandom_range(0, 8191));
                end
            end
        end
        chk("wr_ack_seen", 1, 32'(found), 1);
        chk("wr_cs_cycles", 1, 32'(cnt_cs), 4);
        chk("wr_we_cycles", 1, 32'(cnt_we), 3);
        cpu_req = 1'b0;

        // Display disabled: every window is a CPU window.
        step();
        disp_en  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0100;
        repeat (4) begin
            step();
            if (ack_o[0]) cpu_addr = cpu_addr + 1'b1;
        end
        acks    = 0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                if (st_of(d) != 0) strobes++;
            end
            if (ack_o[0]) begin
                acks++;
                chk("dis_ra", 0, 32'(ra_o[0]), 32'(cpu_addr));
                cpu_addr = cpu_addr + 1'b1;
            end
        end
        chk("dis_acks", 0, 32'(acks), 10);
        chk("dis_strobes", 0, 32'(strobes), 0);
        disp_en = 1'b1;
        cpu_req = 1'b0;

        // Five-layer configuration: one-hot strobes in order, CPU slot is 5.
        repeat (4) step();
        prev     = 0;
        strobes  = 0;
        max_slot = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            st = st_of(2);
            if (int'(slot_of(2)) > max_slot) max_slot = int'(slot_of(2));
            if (st != 0) begin
                strobes++;
                if (prev != 0) chk("l5_order", 2, st, (prev == 16) ? 1 : (prev << 1));
                prev = int'(st);
            end
        end
        chk("l5_max_slot", 2, 32'(max_slot), 5);
        chk("l5_strobe_cnt", 2, 32'(strobes >= 5), 1);

        // Asynchronous reset in the middle of a CPU write.
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 13'h0AAA;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (!wen_o[1] && !ack_o[1]) found = 1;
        end
        chk("mid_wr_seen", 1, 32'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("arst_wen", d, 32'(wen_o[d]), 1);
            chk("arst_csn", d, 32'(csn_o[d]), 1);
            chk("arst_ack", d, 32'(ack_o[d]), 0);
            chk("arst_slot", d, slot_of(d), 0);
        end
        model_reset();
        cpu_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_slot", 1, slot_of(1), 0);
        repeat (12) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step();
            cpu_req  = ($urandom_range(0, 3) != 0);
            cpu_we   = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom_range(0, 8191));
            if ($urandom_range(0, 15) == 0) disp_en = ~disp_en;
            if ($urandom_range(0, 7) == 0) begin
                lay[$urandom_range(0, 2)][$urandom_range(0, 4)] = AW'($urandom_range(0, 8191));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
